// File: rtl/s3g_reg_executor.sv
// S3G command executor with a register file.
// Decodes received packets, updates NUM_REGS 32-bit output registers and launches
// exactly one reply per accepted command.
// Optional feature macro: EXECUTOR_DROP_COUNTER_EN (16-bit dropped-event counter,
// read and cleared by command 0x63; without it 0x63 is an unknown command).
module s3g_reg_executor #(
    parameter int unsigned NUM_REGS = 64,
    parameter logic [15:0] VERSION  = 16'hCEBA
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_packet_done,
    input  logic                    rx_packet_error,
    input  logic [7:0]              rx_payload_len,
    input  logic [127:0]            rx_payload,
    input  logic                    tx_busy,
    output logic                    tx_packet_wr,
    output logic [7:0]              tx_payload_len,
    output logic [127:0]            tx_payload,
    output logic [32*NUM_REGS-1:0]  out_regs,
    output logic                    reg_wr_strobe,
    output logic [7:0]              reg_wr_idx
);

    typedef enum logic [1:0] {StIdle, StDelay, StBusy} state_e;

    state_e         state_q;
    logic           ev;
    logic           accept;
    logic           drop;
    logic [7:0]     b0;
    logic [7:0]     idx;
    logic [31:0]    wdata;
    logic           idx_ok;
    logic [7:0]     rd_idx;
    logic [31:0]    rd_data;
    logic           do_write;
    logic           drop_clr;
    logic [7:0]     rep_len;
    logic [127:0]   rep_payload;
    logic           unused_payload;

    assign b0     = rx_payload[7:0];
    assign idx    = rx_payload[15:8];
    assign wdata  = rx_payload[47:16];
    assign idx_ok = {1'b0, idx} < 9'(NUM_REGS);
    assign rd_idx = idx_ok ? idx : 8'd0;
    assign ev     = rx_packet_done | rx_packet_error;
    // The cycle S_BUSY releases is also a decode slot, giving the N+2 acceptance rate.
    assign accept = ev & ((state_q == StIdle) | ((state_q == StBusy) & ~tx_busy));
    assign drop   = ev & ~accept;

    assign unused_payload = ^rx_payload[127:48];

`ifdef EXECUTOR_DROP_COUNTER_EN
    logic [15:0] drop_cnt_q;

    // Saturating count of events that arrive while a reply is outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= 16'd0;
        end else if (accept && drop_clr) begin
            drop_cnt_q <= {15'd0, drop};
        end else if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

    // Register readback mux; the index is clamped so an illegal index never selects past the bank.
    always_comb begin
        rd_data = 32'd0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_idx == 8'(k)) rd_data = out_regs[32*k +: 32];
        end
    end

    // Command decode into the reply that is registered when the event is accepted.
    always_comb begin
        rep_len     = 8'd1;
        rep_payload = '0;
        do_write    = 1'b0;
        drop_clr    = 1'b0;
        if (rx_packet_done) begin
            if (rx_payload_len == 8'd0) begin
                rep_payload[7:0] = 8'h81;
            end else begin
                case (b0)
                    8'h00: begin
                        rep_len           = 8'd3;
                        rep_payload[23:0] = {VERSION[15:8], VERSION[7:0], 8'h81};
                    end
                    8'h1B: begin
                        rep_len           = 8'd9;
                        rep_payload[71:0] = {24'h0, VERSION[15:8], 8'h00, 8'h01, 8'h00,
                                             8'h01, 8'h81};
                    end
                    8'h60: begin
                        if (rx_payload_len >= 8'd6 && idx_ok) begin
                            rep_payload[7:0] = 8'h81;
                            do_write         = 1'b1;
                        end else begin
                            rep_payload[7:0] = 8'h8A;
                        end
                    end
                    8'h61: begin
                        if (rx_payload_len >= 8'd2 && idx_ok) begin
                            rep_len           = 8'd5;
                            rep_payload[39:0] = {rd_data, 8'h81};
                        end else begin
                            rep_payload[7:0] = 8'h8A;
                        end
                    end
`ifdef EXECUTOR_DROP_COUNTER_EN
                    8'h63: begin
                        rep_len           = 8'd3;
                        rep_payload[23:0] = {drop_cnt_q, 8'h81};
                        drop_clr          = 1'b1;
                    end
`endif
                    default: rep_payload[7:0] = 8'h85;
                endcase
            end
        end else begin
            rep_payload[7:0] = 8'h80;
        end
    end

    // Reply FSM with registered reply outputs and register-file writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            tx_packet_wr   <= 1'b0;
            tx_payload_len <= 8'd0;
            tx_payload     <= '0;
            reg_wr_strobe  <= 1'b0;
            reg_wr_idx     <= 8'd0;
            out_regs       <= '0;
        end else begin
            tx_packet_wr   <= 1'b0;
            tx_payload_len <= 8'd0;
            tx_payload     <= '0;
            reg_wr_strobe  <= 1'b0;
            reg_wr_idx     <= 8'd0;
            if (accept) begin
                state_q        <= StDelay;
                tx_packet_wr   <= 1'b1;
                tx_payload_len <= rep_len;
                tx_payload     <= rep_payload;
                if (do_write) begin
                    reg_wr_strobe <= 1'b1;
                    reg_wr_idx    <= idx;
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (idx == 8'(k)) out_regs[32*k +: 32] <= wdata;
                    end
                end
            end else begin
                case (state_q)
                    StIdle:  state_q <= StIdle;
                    StDelay: state_q <= StBusy;
                    StBusy:  state_q <= tx_busy ? StBusy : StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
